// File: rtl/dcache_wbuf_pkg.sv
// Shared definitions for the D-cache line write buffer.
package dcache_wbuf_pkg;

   localparam int unsigned ADDR_W_DEF = 28;   // line address, byte address bits 31:4
   localparam int unsigned LINE_W_DEF = 128;  // one cache line

   // Memory-port FSM encoding
   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t StIdle = 2'd0;
   localparam fsm_state_t StRd   = 2'd1;
   localparam fsm_state_t StWr   = 2'd2;

   // Buffer entry layout at the default widths
   typedef struct packed {
      logic                  valid;
      logic [ADDR_W_DEF-1:0] addr;
      logic [LINE_W_DEF-1:0] data;
   } wbuf_entry_t;

endpackage

// File: rtl/wbuf_entry_array.sv
// Circular store of buffered lines: enqueue at tail, pop at head, in-place data
// update for coalescing, and a combinational address lookup.
module wbuf_entry_array
   import dcache_wbuf_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LINE_W = LINE_W_DEF,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              proc_reset,
   // enqueue at tail
   input  logic              enq_en,
   input  logic [ADDR_W-1:0] enq_addr,
   input  logic [LINE_W-1:0] enq_data,
   // coalescing data overwrite
   input  logic              upd_en,
   input  logic [PTR_W-1:0]  upd_idx,
   input  logic [LINE_W-1:0] upd_data,
   // pop head
   input  logic              pop_en,
   // lookup
   input  logic [ADDR_W-1:0] lookup_addr,
   input  logic              excl_head,
   output logic              hit,
   output logic [PTR_W-1:0]  hit_idx,
   output logic [LINE_W-1:0] hit_data,
   // head entry and occupancy
   output logic              head_valid,
   output logic [PTR_W-1:0]  head_ptr,
   output logic [ADDR_W-1:0] head_addr,
   output logic [LINE_W-1:0] head_data,
   output logic [CNT_W-1:0]  count
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } entry_t;

   entry_t           entries_q [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;

   // Entry storage, pointers and occupancy; only valid bits need clearing on reset
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i].valid <= 1'b0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq_en) begin
            entries_q[tail_q].valid <= 1'b1;
            entries_q[tail_q].addr  <= enq_addr;
            entries_q[tail_q].data  <= enq_data;
            tail_q                  <= tail_q + PTR_W'(1);
         end
         if (upd_en) begin
            entries_q[upd_idx].data <= upd_data;
         end
         if (pop_en) begin
            entries_q[head_q].valid <= 1'b0;
            head_q                  <= head_q + PTR_W'(1);
         end
         if (enq_en && !pop_en) begin
            count_q <= count_q + CNT_W'(1);
         end else if (!enq_en && pop_en) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   // Address match over valid entries; the head may be excluded while it is in flight
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries_q[i].valid && (entries_q[i].addr == lookup_addr) &&
             !(excl_head && (PTR_W'(i) == head_q))) begin
            hit      = 1'b1;
            hit_idx  = PTR_W'(i);
            hit_data = entries_q[i].data;
         end
      end
   end

   assign head_valid = entries_q[head_q].valid;
   assign head_ptr   = head_q;
   assign head_addr  = entries_q[head_q].addr;
   assign head_data  = entries_q[head_q].data;
   assign count      = count_q;

endmodule

// File: rtl/dcache_write_buffer.sv
// Line write buffer between the D-cache memory port and slow data memory.
// Write-backs are acknowledged from the buffer, reads hit buffered lines or
// bypass pending writes, and the buffer drains whenever memory is idle.
module dcache_write_buffer
   import dcache_wbuf_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              c_read,
   input  logic              c_write,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [LINE_W-1:0] c_wdata,
   output logic [LINE_W-1:0] c_rdata,
   output logic              c_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              buf_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic              arr_hit;
   logic [PTR_W-1:0]  arr_hit_idx;
   logic [LINE_W-1:0] arr_hit_data;
   logic              head_valid;
   logic [PTR_W-1:0]  head_ptr;
   logic [ADDR_W-1:0] head_addr;
   logic [LINE_W-1:0] head_data;
   logic [CNT_W-1:0]  count;

   fsm_state_t        state_q, state_d;
   logic              c_ready_q, c_ready_d;
   logic [LINE_W-1:0] c_rdata_q, c_rdata_d;
   logic              mem_read_q, mem_write_q;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              buf_empty_q, buf_empty_d;

   logic              req_ok, in_wr, head_hit, rd_hit;
   logic              wr_coalesce, wr_enq, rd_hit_ack, rd_miss, pop;
   logic [LINE_W-1:0] rd_hit_data;
   logic [CNT_W-1:0]  count_nxt;

   wbuf_entry_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) u_array (
      .clk         (clk),
      .proc_reset  (proc_reset),
      .enq_en      (wr_enq),
      .enq_addr    (c_addr),
      .enq_data    (c_wdata),
      .upd_en      (wr_coalesce),
      .upd_idx     (arr_hit_idx),
      .upd_data    (c_wdata),
      .pop_en      (pop),
      .lookup_addr (c_addr),
      .excl_head   (in_wr),
      .hit         (arr_hit),
      .hit_idx     (arr_hit_idx),
      .hit_data    (arr_hit_data),
      .head_valid  (head_valid),
      .head_ptr    (head_ptr),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .count       (count)
   );

   // Classify the cache request; in RD the held read is the one being serviced
   always_comb begin
      req_ok      = (c_read | c_write) & ~c_ready_q & (state_q != StRd);
      in_wr       = (state_q == StWr);
      head_hit    = in_wr & head_valid & (head_addr == c_addr);
      rd_hit      = arr_hit | head_hit;
      rd_hit_data = arr_hit ? arr_hit_data : head_data;
      wr_coalesce = req_ok & c_write & arr_hit;
      wr_enq      = req_ok & c_write & ~arr_hit & (count < FULL_CNT);
      rd_hit_ack  = req_ok & c_read & rd_hit;
      rd_miss     = req_ok & c_read & ~rd_hit;
      pop         = in_wr & mem_ready;
      count_nxt   = count;
      if (wr_enq && !pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (!wr_enq && pop) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // Memory-port FSM: read misses win over draining; a miss waiting on a drain
   // goes straight to RD when the write completes
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (rd_miss) begin
               state_d = StRd;
            end else if (count != '0) begin
               state_d = StWr;
            end
         end
         StRd: begin
            if (mem_ready) begin
               state_d = StIdle;
            end
         end
         StWr: begin
            if (mem_ready) begin
               state_d = rd_miss ? StRd : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      c_ready_d = rd_hit_ack | wr_coalesce | wr_enq | ((state_q == StRd) & mem_ready);
      c_rdata_d = c_rdata_q;
      if (rd_hit_ack) begin
         c_rdata_d = rd_hit_data;
      end else if ((state_q == StRd) && mem_ready) begin
         c_rdata_d = mem_rdata;
      end
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if ((state_q != StRd) && (state_d == StRd)) begin
         mem_addr_d = c_addr;
      end else if ((state_q == StIdle) && (state_d == StWr)) begin
         mem_addr_d  = head_addr;
         // a write coalescing into the head this very cycle must reach memory
         mem_wdata_d = (wr_coalesce && (arr_hit_idx == head_ptr)) ? c_wdata : head_data;
      end
      buf_empty_d = (count_nxt == '0) && (state_d == StIdle);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q     <= StIdle;
         c_ready_q   <= 1'b0;
         c_rdata_q   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         buf_empty_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         c_ready_q   <= c_ready_d;
         c_rdata_q   <= c_rdata_d;
         mem_read_q  <= (state_d == StRd);
         mem_write_q <= (state_d == StWr);
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         buf_empty_q <= buf_empty_d;
      end
   end

   assign c_ready   = c_ready_q;
   assign c_rdata   = c_rdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign buf_empty = buf_empty_q;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: writes, coalescing, read hits,
// read-miss bypass, full-buffer stall and reset behaviour.
module tb_dcache_write_buffer;

   logic         clk;
   logic         proc_reset;
   logic         c_read;
   logic         c_write;
   logic [27:0]  c_addr;
   logic [127:0] c_wdata;
   logic [127:0] c_rdata;
   logic         c_ready;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic         buf_empty;

   int   checks = 0;
   int   failures = 0;
   logic both_seen = 1'b0;

   dcache_write_buffer #(
      .DEPTH  (4),
      .ADDR_W (28),
      .LINE_W (128)
   ) dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .c_read     (c_read),
      .c_write    (c_write),
      .c_addr     (c_addr),
      .c_wdata    (c_wdata),
      .c_rdata    (c_rdata),
      .c_ready    (c_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .buf_empty  (buf_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_read === 1'b1 && mem_write === 1'b1) both_seen <= 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait (bounded) for c_ready, drop it, step one cycle.
   task automatic do_req(input logic rd, input logic wr, input logic [27:0] a,
                         input logic [127:0] d, output int lat, output logic [127:0] rdata);
      c_read  = rd;
      c_write = wr;
      c_addr  = a;
      c_wdata = d;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (c_ready !== 1'b1 && lat < 40);
      rdata   = c_rdata;
      c_read  = 1'b0;
      c_write = 1'b0;
      tick();
   endtask

   // Wait (bounded) for a memory write, check it, complete it, check the idle gap.
   task automatic drain_one(input string tag, input logic [27:0] a, input logic [127:0] d);
      int n = 0;
      while (mem_write !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_wr"}, 128'(mem_write), 128'(1));
      chk({tag, "_addr"}, 128'(mem_addr), 128'(a));
      chk({tag, "_data"}, mem_wdata, d);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk({tag, "_gap"}, 128'(mem_write), 128'(0));
   endtask

   task automatic mem_pulse(input logic [127:0] rd);
      mem_rdata = rd;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
   endtask

   initial begin
      int           lat;
      logic [127:0] rdata;
      logic [127:0] dv [5];
      logic [127:0] d_a5, d1, d2, dr;
      logic         ok;

      d_a5 = {16{8'hA5}};
      d1   = {4{32'hD1D1_0001}};
      d2   = {4{32'hD2D2_0002}};
      dr   = {4{32'hBEEF_0099}};
      for (int i = 0; i < 5; i++) dv[i] = {4{32'hC0DE_0000 | 32'(i)}};

      proc_reset = 1'b1;
      c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      tick();
      tick();
      proc_reset = 1'b0;

      // Reset state
      chk("rst_c_ready", 128'(c_ready), 128'(0));
      chk("rst_mem_read", 128'(mem_read), 128'(0));
      chk("rst_mem_write", 128'(mem_write), 128'(0));
      chk("rst_buf_empty", 128'(buf_empty), 128'(1));
      chk("rst_c_rdata", c_rdata, 128'(0));
      chk("rst_mem_addr", 128'(mem_addr), 128'(0));
      chk("rst_mem_wdata", mem_wdata, 128'(0));

      // Single write-back then drain
      do_req(1'b0, 1'b1, 28'h0000010, d_a5, lat, rdata);
      chk("t1_ack_lat", 128'(lat), 128'(1));
      chk("t1_ack_one_cycle", 128'(c_ready), 128'(0));
      chk("t1_not_empty", 128'(buf_empty), 128'(0));
      chk("t1_wr_now", 128'(mem_write), 128'(1));
      tick();
      tick();
      chk("t1_wr_held", 128'(mem_write), 128'(1));
      chk("t1_addr_held", 128'(mem_addr), 128'h10);
      drain_one("t1", 28'h0000010, d_a5);
      chk("t1_empty", 128'(buf_empty), 128'(1));

      // Fill with memory stalled, fifth write waits for a free slot
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, 1'b1, 28'(16 * (i + 1)), dv[i], lat, rdata);
         chk($sformatf("t2_ack%0d", i), 128'(lat), 128'(1));
      end
      c_write = 1'b1;
      c_addr  = 28'h50;
      c_wdata = dv[4];
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (c_ready !== 1'b0) ok = 1'b0;
      end
      chk("t2_full_stall", 128'(ok), 128'(1));
      mem_pulse('0);
      chk("t2_m1_no_ready", 128'(c_ready), 128'(0));
      chk("t2_m1_idle", 128'(mem_write), 128'(0));
      tick();
      chk("t2_m2_ready", 128'(c_ready), 128'(1));
      c_write = 1'b0;
      tick();
      for (int i = 1; i < 5; i++) begin
         drain_one($sformatf("t2_drain%0d", i), 28'(16 * (i + 1)), dv[i]);
      end
      chk("t2_empty", 128'(buf_empty), 128'(1));

      // Read hit on a buffered line
      do_req(1'b0, 1'b1, 28'h20, d1, lat, rdata);
      do_req(1'b1, 1'b0, 28'h20, '0, lat, rdata);
      chk("t3_hit_lat", 128'(lat), 128'(1));
      chk("t3_hit_data", rdata, d1);
      chk("t3_no_mem_read", 128'(mem_read), 128'(0));
      drain_one("t3", 28'h20, d1);
      chk("t3_no_mem_read2", 128'(mem_read), 128'(0));

      // Coalescing: second write to 0x30 replaces the first
      do_req(1'b0, 1'b1, 28'h10, dv[0], lat, rdata);
      do_req(1'b0, 1'b1, 28'h30, d1, lat, rdata);
      chk("t4_w1_lat", 128'(lat), 128'(1));
      do_req(1'b0, 1'b1, 28'h30, d2, lat, rdata);
      chk("t4_w2_lat", 128'(lat), 128'(1));
      drain_one("t4_a", 28'h10, dv[0]);
      drain_one("t4_b", 28'h30, d2);
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mem_write !== 1'b0) ok = 1'b0;
      end
      chk("t4_single_write", 128'(ok), 128'(1));
      chk("t4_empty", 128'(buf_empty), 128'(1));

      // Read miss waits for the in-flight drain, then bypasses to memory
      do_req(1'b0, 1'b1, 28'h10, dv[1], lat, rdata);
      c_read = 1'b1;
      c_addr = 28'h99;
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (c_ready !== 1'b0 || mem_read !== 1'b0) ok = 1'b0;
      end
      chk("t5_wait_drain", 128'(ok), 128'(1));
      mem_pulse('0);
      chk("t5_rd_next", 128'(mem_read), 128'(1));
      chk("t5_wr_done", 128'(mem_write), 128'(0));
      chk("t5_rd_addr", 128'(mem_addr), 128'h99);
      tick();
      tick();
      mem_pulse(dr);
      chk("t5_ready", 128'(c_ready), 128'(1));
      chk("t5_rdata", c_rdata, dr);
      c_read = 1'b0;
      tick();
      chk("t5_rd_off", 128'(mem_read), 128'(0));
      chk("t5_empty", 128'(buf_empty), 128'(1));

      // Reset during a read miss
      c_read = 1'b1;
      c_addr = 28'h77;
      tick();
      chk("t6_rd_issued", 128'(mem_read), 128'(1));
      proc_reset = 1'b1;
      c_read = 1'b0;
      tick();
      proc_reset = 1'b0;
      chk("t6a_mem_read", 128'(mem_read), 128'(0));
      chk("t6a_c_rdata", c_rdata, 128'(0));
      chk("t6a_mem_addr", 128'(mem_addr), 128'(0));
      chk("t6a_buf_empty", 128'(buf_empty), 128'(1));
      chk("t6a_c_ready", 128'(c_ready), 128'(0));

      // Reset with a full buffer and a drain in flight
      for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 28'(16 * (i + 1)), dv[i], lat, rdata);
      chk("t6b_draining", 128'(mem_write), 128'(1));
      proc_reset = 1'b1;
      tick();
      proc_reset = 1'b0;
      chk("t6b_mem_write", 128'(mem_write), 128'(0));
      chk("t6b_mem_addr", 128'(mem_addr), 128'(0));
      chk("t6b_mem_wdata", mem_wdata, 128'(0));
      chk("t6b_buf_empty", 128'(buf_empty), 128'(1));
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (mem_write !== 1'b0) ok = 1'b0;
      end
      chk("t6b_no_stale", 128'(ok), 128'(1));
      do_req(1'b0, 1'b1, 28'h60, d2, lat, rdata);
      drain_one("t6b_fresh", 28'h60, d2);
      chk("t6b_empty", 128'(buf_empty), 128'(1));

      chk("never_both", 128'(both_seen), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
